data_sram_slave: RTL and testbench
==================================

# data_sram_slave

Data-side SRAM-like responder for the pipelined core: the memory end of the `data_req`/`data_addr_ok`/`data_data_ok`/`data_rdata` protocol that the M stage issues and the W stage consumes. It accepts byte/half/word loads and stores, holds a word-addressed on-chip array, and returns in-order responses after a fixed latency, with a bounded number of outstanding requests. It serves as the data memory in simulation and FPGA builds, and as the stall source that exercises W-stage `ready_go`.

## Interface
- `LATENCY`, 2: cycles from request acceptance to `data_data_ok`; legal range 1..8.
- `MAX_OUT`, 2: maximum accepted-but-unanswered requests; legal range 1..4.
- `AW`, 10: word-index width; the array holds 2^AW 32-bit words.

- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low; 0 = reset.
- `data_req` in 1: request valid.
- `data_wr` in 1: 1 = store, 0 = load.
- `data_size` in 2: 0 = byte, 1 = half, 2 = word; 3 is treated as word.
- `data_addr` in 32: byte address.
- `data_wdata` in 32: store data, lane-aligned (byte in the lane selected by `addr[1:0]`).
- `data_addr_ok` out 1: request accepted this cycle (combinational).
- `data_data_ok` out 1: one-cycle response pulse.
- `data_rdata` out 32: full aligned word for loads; the receiver extracts the byte or half.

## Operation
- Acceptance: `data_addr_ok = reset && data_req && (count < MAX_OUT || pop)`. Here `pop` means the head entry responds this cycle. A request is accepted on the edge where `data_req && data_addr_ok`.
- Word index = `data_addr[AW+1:2]`. Upper address bits are ignored, so addresses wrap modulo 2^(AW+2).
- Store byte enables:
  - size 0: one lane at `addr[1:0]`.
  - size 1: lanes {1:0} or {3:2} by `addr[1]`.
  - size 2/3: all four lanes.
- Misaligned stores (half with `addr[0]`=1, word with `addr[1:0]`≠0) do not update the array but still receive `data_data_ok`.
- Stores update the array on the acceptance edge.
- Loads capture the array word on the acceptance edge into the queue entry. A later-accepted store therefore never alters an earlier load's data, and a load accepted after a store sees the stored value.
- Queue: in-order FIFO of `MAX_OUT` entries. Each entry holds {wr, data, countdown}; countdown is set to `LATENCY-1` on push and decrements every cycle.
- Response: when the head countdown is 0, `data_data_ok`=1 for exactly that cycle, the entry pops, and `data_rdata` is loaded with the entry data (loads only). There is no backpressure: the receiver must take the pulse.
- `data_rdata` holds its last load value between responses. Store responses leave it unchanged.
- Simultaneous push and pop while full is permitted, and `count` is unchanged.
- The array is not reset or initialised; X-reads propagate.

## Timing
- Reset values: `data_addr_ok`=0, `data_data_ok`=0, `data_rdata`=0, queue empty, `count`=0.
- Reset asserted mid-operation: all pending entries are discarded, no `data_data_ok` is produced for them, and array contents are retained.
- Latency: accepted at edge T → `data_data_ok` high in cycle T+`LATENCY`, i.e. sampled at edge T+`LATENCY`.
- Throughput: one request per cycle sustained when `MAX_OUT` ≥ `LATENCY`; otherwise `MAX_OUT` requests per `LATENCY` cycles.
- `data_addr_ok` depends combinationally on `data_req`. `data_data_ok` and `data_rdata` are registered.

## Configuration
- `DSRAM_STALL_INJECT_EN`:
  - Defined: an 8-bit Fibonacci LFSR (taps 8,6,5,4, seed 0xA5 on reset) advances every cycle, and `data_addr_ok` is additionally forced to 0 whenever `lfsr[0]`=1. This produces pseudo-random request stalls; latency after acceptance is unchanged.
  - Undefined: no LFSR exists and acceptance follows the rule above only.

## Test plan
- Store word 0xDEADBEEF to 0x100, then load 0x100 (LATENCY=2) → second `data_data_ok` at acceptance+2 with `data_rdata`=0xDEADBEEF.
- Store byte 0x77 (lane 2) to 0x102 over word 0x11223344, then load word → 0x11773344. Half store 0xABCD to 0x101 (misaligned) → `data_data_ok` pulses and the word is unchanged.
- Hold `data_req`=1 for 6 back-to-back loads (LATENCY=2, MAX_OUT=2) → `data_addr_ok`=1 every cycle and six consecutive `data_data_ok` pulses in order.
- MAX_OUT=1, LATENCY=3, constant requests → `data_addr_ok` high only on the response cycles after the first; one response every 3 cycles.
- Pull `reset` low one cycle after two loads are accepted → no `data_data_ok`, `data_rdata`=0. After release, loading the earlier-stored address returns the retained data.
- With `DSRAM_STALL_INJECT_EN`, issue 100 loads → exactly 100 in-order responses, and `data_addr_ok`=0 on every cycle where `lfsr[0]`=1.

Source files
------------

// File: rtl/data_sram_slave.sv
// Data-side SRAM-like responder: byte/half/word loads and stores with fixed-latency, in-order responses.
// Optional build macro DSRAM_STALL_INJECT_EN adds LFSR-driven pseudo-random request stalls.
module data_sram_slave #(
    parameter int LATENCY = 2,
    parameter int MAX_OUT = 2,
    parameter int AW      = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata
);

    typedef struct packed {
        logic        wr;
        logic [31:0] data;
        logic [2:0]  cd;
    } entry_t;

    localparam logic [2:0] CD_INIT = 3'(LATENCY - 1);

    logic [31:0]   mem [2**AW];
    entry_t        q_q [MAX_OUT];
    entry_t        q_d [MAX_OUT];
    logic [2:0]    count_q, count_d;
    logic          data_ok_q, data_ok_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [AW-1:0] word_idx;
    logic [31:0]   rd_word;
    logic [3:0]    be;
    logic          accept;
    logic          pop;
    logic          stall;
    logic          unused_addr_bits;

    assign word_idx         = data_addr[AW+1:2];
    assign rd_word          = mem[word_idx];
    assign unused_addr_bits = ^data_addr[31:AW+2];

    // The response register is high exactly while the head entry is being answered.
    assign pop          = data_ok_q;
    assign data_addr_ok = reset && data_req && !stall && ((count_q < 3'(MAX_OUT)) || pop);
    assign accept       = data_addr_ok;

    assign data_data_ok = data_ok_q;
    assign data_rdata   = rdata_q;

`ifdef DSRAM_STALL_INJECT_EN
    logic [7:0] lfsr_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr_q <= 8'hA5;
        end else begin
            lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        end
    end

    assign stall = lfsr_q[0];
`else
    assign stall = 1'b0;
`endif

    // Misaligned half/word stores produce no enables but still flow through the queue.
    always_comb begin
        be = 4'b0000;
        case (data_size)
            2'd0:    be = 4'b0001 << data_addr[1:0];
            2'd1:    if (!data_addr[0]) be = data_addr[1] ? 4'b1100 : 4'b0011;
            default: if (data_addr[1:0] == 2'b00) be = 4'b1111;
        endcase
    end

    // NOTE: the array carries no reset so it maps onto RAM and keeps its contents across reset.
    always_ff @(posedge clk) begin
        if (accept && data_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[word_idx][8*b +: 8] <= data_wdata[8*b +: 8];
            end
        end
    end

    // NOTE: every output of this block gets a default first, so no latches are inferred.
    always_comb begin
        q_d     = q_q;
        count_d = count_q;
        for (int i = 0; i < MAX_OUT; i++) begin
            if (q_d[i].cd != 3'd0) q_d[i].cd = q_d[i].cd - 3'd1;
        end
        if (pop) begin
            for (int i = 0; i < MAX_OUT - 1; i++) q_d[i] = q_d[i+1];
            count_d = count_d - 3'd1;
        end
        if (accept) begin
            for (int i = 0; i < MAX_OUT; i++) begin
                if (3'(i) == count_d) q_d[i] = '{wr: data_wr, data: rd_word, cd: CD_INIT};
            end
            count_d = count_d + 3'd1;
        end
        data_ok_d = (count_d != 3'd0) && (q_d[0].cd == 3'd0);
        rdata_d   = rdata_q;
        if (data_ok_d && !q_d[0].wr) rdata_d = q_d[0].data;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < MAX_OUT; i++) q_q[i] <= '0;
            count_q   <= 3'd0;
            data_ok_q <= 1'b0;
            rdata_q   <= 32'h0;
        end else begin
            q_q       <= q_d;
            count_q   <= count_d;
            data_ok_q <= data_ok_d;
            rdata_q   <= rdata_d;
        end
    end

endmodule

// File: tb/tb_data_sram_slave.sv
// Self-checking bench for data_sram_slave: directed vectors, corner sequences and a random run
// checked against a due-time based reference model.
module tb_data_sram_slave;

    localparam int LAT_A = 2;
    localparam int MAX_A = 2;
    localparam int LAT_B = 3;
    localparam int MAX_B = 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        a_req, a_wr, a_addr_ok, a_dok;
    logic [1:0]  a_size;
    logic [31:0] a_addr, a_wdata, a_rdata;
    logic        b_req, b_wr, b_addr_ok, b_dok;
    logic [1:0]  b_size;
    logic [31:0] b_addr, b_wdata, b_rdata;

    data_sram_slave #(.LATENCY(LAT_A), .MAX_OUT(MAX_A), .AW(10)) u_a (
        .clk(clk), .reset(reset), .data_req(a_req), .data_wr(a_wr), .data_size(a_size),
        .data_addr(a_addr), .data_wdata(a_wdata), .data_addr_ok(a_addr_ok),
        .data_data_ok(a_dok), .data_rdata(a_rdata)
    );

    data_sram_slave #(.LATENCY(LAT_B), .MAX_OUT(MAX_B), .AW(10)) u_b (
        .clk(clk), .reset(reset), .data_req(b_req), .data_wr(b_wr), .data_size(b_size),
        .data_addr(b_addr), .data_wdata(b_wdata), .data_addr_ok(b_addr_ok),
        .data_data_ok(b_dok), .data_rdata(b_rdata)
    );

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    always @(posedge clk) cyc <= cyc + 1;

`ifdef DSRAM_STALL_INJECT_EN
    logic [7:0] m_lfsr;
    always @(posedge clk or negedge reset) begin
        if (!reset) m_lfsr <= 8'hA5;
        else        m_lfsr <= {m_lfsr[6:0], ^(m_lfsr & 8'b1011_1000)};
    end
    function automatic logic model_stall();
        return m_lfsr[0];
    endfunction
`else
    function automatic logic model_stall();
        return 1'b0;
    endfunction
`endif

    typedef struct {
        int          due;
        logic        wr;
        logic [31:0] data;
    } pend_t;

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    pend_t       pq [$];
    logic [31:0] mmem [int];
    logic [31:0] last_rd = 32'h0;
    logic        seen_dok;
    logic [31:0] seen_rd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_word(input logic [31:0] addr);
        int w = int'(addr[11:2]);
        return mmem.exists(w) ? mmem[w] : 32'hxxxx_xxxx;
    endfunction

    function automatic void model_store(input logic [31:0] addr, input logic [1:0] size,
                                        input logic [31:0] wd);
        int          off = int'(addr[1:0]);
        logic [31:0] v   = model_word(addr);
        if (size == 2'd0) begin
            v[off*8 +: 8] = wd[off*8 +: 8];
        end else if (size == 2'd1) begin
            if (off % 2 != 0) return;
            v[off*8 +: 16] = wd[off*8 +: 16];
        end else begin
            if (off != 0) return;
            v = wd;
        end
        mmem[int'(addr[11:2])] = v;
    endfunction

    // One clock cycle on u_a: entered and left at a falling edge.
    task automatic step_a(input logic req, input logic wr, input logic [1:0] size,
                          input logic [31:0] addr, input logic [31:0] wd, output logic acc);
        logic exp_pop, exp_ok;
        exp_pop  = (pq.size() != 0) && (pq[0].due == cyc + 1);
        seen_dok = a_dok;
        seen_rd  = a_rdata;
        check("a_data_ok", 32'(a_dok), 32'(exp_pop));
        if (exp_pop && !pq[0].wr) last_rd = pq[0].data;
        check("a_rdata", a_rdata, last_rd);
        exp_ok = req && ((pq.size() < MAX_A) || exp_pop) && !model_stall();
        if (exp_pop) void'(pq.pop_front());
        a_req = req; a_wr = wr; a_size = size; a_addr = addr; a_wdata = wd;
        #1;
        check("a_addr_ok", 32'(a_addr_ok), 32'(exp_ok));
        if (exp_ok) begin
            pq.push_back('{due: cyc + 1 + LAT_A, wr: wr, data: wr ? 32'h0 : model_word(addr)});
            if (wr) model_store(addr, size, wd);
        end
        acc = exp_ok;
        @(negedge clk);
    endtask

    task automatic idle_a(input int n);
        logic acc;
        for (int i = 0; i < n; i++) step_a(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, acc);
    endtask

    task automatic txn_a(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                         input logic [31:0] wd, output logic [31:0] rd, output int lat);
        logic acc = 1'b0;
        int   n   = 0;
        rd  = 32'hxxxx_xxxx;
        lat = -1;
        while (!acc && n < 64) begin
            step_a(1'b1, wr, size, addr, wd, acc);
            n++;
        end
        if (!acc) begin
            check("a_accept_timeout", 32'h0, 32'h1);
            return;
        end
        for (int k = 1; k <= 32; k++) begin
            step_a(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, acc);
            if (seen_dok) begin
                lat = k;
                rd  = seen_rd;
                break;
            end
        end
        if (lat < 0) check("a_response_timeout", 32'h0, 32'h1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs [22];
        logic [31:0] rd;
        int          lat;
        logic        acc;
        logic [31:0] got [$];
        int          idx [$];

        vecs[0]  = '{1'b1, 2'd2, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0};
        vecs[1]  = '{1'b0, 2'd2, 32'h0000_0100, 32'h0,         32'hDEAD_BEEF};
        vecs[2]  = '{1'b1, 2'd2, 32'h0000_0200, 32'h1122_3344, 32'h0};
        vecs[3]  = '{1'b1, 2'd0, 32'h0000_0202, 32'h0077_0000, 32'h0};
        vecs[4]  = '{1'b0, 2'd2, 32'h0000_0200, 32'h0,         32'h1177_3344};
        vecs[5]  = '{1'b1, 2'd1, 32'h0000_0201, 32'h00AB_CD00, 32'h0};
        vecs[6]  = '{1'b0, 2'd2, 32'h0000_0200, 32'h0,         32'h1177_3344};
        vecs[7]  = '{1'b1, 2'd1, 32'h0000_0202, 32'hBEEF_0000, 32'h0};
        vecs[8]  = '{1'b0, 2'd2, 32'h0000_0200, 32'h0,         32'hBEEF_3344};
        vecs[9]  = '{1'b1, 2'd0, 32'h0000_0203, 32'hAA00_0000, 32'h0};
        vecs[10] = '{1'b0, 2'd2, 32'h0000_0200, 32'h0,         32'hAAEF_3344};
        vecs[11] = '{1'b1, 2'd2, 32'h0000_0202, 32'h1234_5678, 32'h0};
        vecs[12] = '{1'b0, 2'd2, 32'h0000_0200, 32'h0,         32'hAAEF_3344};
        vecs[13] = '{1'b1, 2'd3, 32'h0000_0300, 32'h0BAD_F00D, 32'h0};
        vecs[14] = '{1'b0, 2'd2, 32'h0000_0300, 32'h0,         32'h0BAD_F00D};
        vecs[15] = '{1'b1, 2'd1, 32'h0000_0300, 32'h0000_5A5A, 32'h0};
        vecs[16] = '{1'b0, 2'd2, 32'h0000_0300, 32'h0,         32'h0BAD_5A5A};
        vecs[17] = '{1'b1, 2'd2, 32'h0000_1100, 32'hCAFE_F00D, 32'h0};
        vecs[18] = '{1'b0, 2'd2, 32'h0000_0100, 32'h0,         32'hCAFE_F00D};
        vecs[19] = '{1'b0, 2'd0, 32'hFFFF_F100, 32'h0,         32'hCAFE_F00D};
        vecs[20] = '{1'b1, 2'd0, 32'h0000_0300, 32'h0000_00EE, 32'h0};
        vecs[21] = '{1'b0, 2'd1, 32'h0000_0301, 32'h0,         32'h0BAD_5AEE};

        reset = 1'b0;
        a_req = 1'b1; a_wr = 1'b0; a_size = 2'd2; a_addr = 32'h0; a_wdata = 32'h0;
        b_req = 1'b1; b_wr = 1'b0; b_size = 2'd2; b_addr = 32'h0; b_wdata = 32'h0;
        #2;
        check("rst_a_addr_ok", 32'(a_addr_ok), 32'h0);
        check("rst_a_data_ok", 32'(a_dok), 32'h0);
        check("rst_a_rdata", a_rdata, 32'h0);
        check("rst_b_addr_ok", 32'(b_addr_ok), 32'h0);
        check("rst_b_data_ok", 32'(b_dok), 32'h0);
        a_req = 1'b0; b_req = 1'b0;
        @(negedge clk); @(negedge clk);
        reset = 1'b1;

        // Directed vectors: one transaction at a time, latency and load data checked.
        for (int i = 0; i < 22; i++) begin
            txn_a(vecs[i].wr, vecs[i].size, vecs[i].addr, vecs[i].wdata, rd, lat);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(LAT_A));
            if (!vecs[i].wr) check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp);
        end

`ifndef DSRAM_STALL_INJECT_EN
        // MAX_OUT=1, LATENCY=3 with a constant request: accept every third cycle.
        b_req = 1'b1; b_wr = 1'b0; b_size = 2'd2; b_addr = 32'h0;
        for (int k = 0; k < 12; k++) begin
            #1;
            check($sformatf("b_addr_ok_k%0d", k), 32'(b_addr_ok), 32'(k % 3 == 0));
            check($sformatf("b_data_ok_k%0d", k), 32'(b_dok), 32'(k % 3 == 0 && k > 0));
            @(negedge clk);
        end
        b_req = 1'b0;
`endif

        for (int i = 0; i < 16; i++) begin
            txn_a(1'b1, 2'd2, 32'h400 + 32'(i * 4), 32'hC0DE_0000 + 32'(i * 32'h111), rd, lat);
        end

`ifndef DSRAM_STALL_INJECT_EN
        // Six back-to-back loads: accepted every cycle, six consecutive in-order pulses.
        for (int s = 0; s < 12; s++) begin
            if (s < 6) begin
                step_a(1'b1, 1'b0, 2'd2, 32'h400 + 32'(s * 4), 32'h0, acc);
                check($sformatf("b2b_accept%0d", s), 32'(acc), 32'h1);
            end else begin
                step_a(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, acc);
            end
            if (seen_dok) begin
                got.push_back(seen_rd);
                idx.push_back(s);
            end
        end
        check("b2b_count", 32'(got.size()), 32'd6);
        for (int i = 0; i < got.size(); i++) begin
            check($sformatf("b2b_data%0d", i), got[i], 32'hC0DE_0000 + 32'(i * 32'h111));
            check($sformatf("b2b_spacing%0d", i), 32'(idx[i] - idx[0]), 32'(i));
        end
`endif

        // Reset right after the second of two loads is accepted: both are discarded.
        step_a(1'b1, 1'b0, 2'd2, 32'h404, 32'h0, acc);
        fork
            step_a(1'b1, 1'b0, 2'd2, 32'h408, 32'h0, acc);
            begin
                @(posedge clk);
                #1 reset = 1'b0;
            end
        join
        pq.delete();
        last_rd = 32'h0;
        a_req   = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("rstmid_data_ok", 32'(a_dok), 32'h0);
            check("rstmid_rdata", a_rdata, 32'h0);
            check("rstmid_addr_ok", 32'(a_addr_ok), 32'h0);
            @(negedge clk);
        end
        reset = 1'b1;
        idle_a(6);
        txn_a(1'b0, 2'd2, 32'h404, 32'h0, rd, lat);
        check("retained_0x404", rd, 32'hC0DE_0111);
        txn_a(1'b0, 2'd2, 32'h100, 32'h0, rd, lat);
        check("retained_0x100", rd, 32'hCAFE_F00D);

        // Random traffic over the initialised window, upper address bits scrambled.
        for (int s = 0; s < 400; s++) begin
            logic        r, w;
            logic [1:0]  sz;
            logic [31:0] ad, wd;
            r  = ($urandom_range(0, 3) != 0);
            w  = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            ad = {20'($urandom), 12'h400 + 12'($urandom_range(0, 15) * 4) + 12'($urandom_range(0, 3))};
            wd = $urandom;
            step_a(r, w, sz, ad, wd, acc);
        end
        idle_a(12);
        check("drain_empty", 32'(pq.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
